// File: rtl/snake_move_ctrl.sv
// Turns snake direction/pause/start buttons into digit_store load and shift strobes.
// Optional macro SNAKE_HIT_STOP_EN: a set edge bit at a tick ends the game (DEAD state).
module snake_move_ctrl #(
  parameter int         TICK_DIV  = 50000000,
  parameter logic [2:0] START_POS = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_pause,
  input  logic       edge_up,
  input  logic       edge_down,
  input  logic       edge_left,
  input  logic       edge_right,
  output logic       set,
  output logic [2:0] user_input,
  output logic       up_shift,
  output logic       down_shift,
  output logic       left_shift,
  output logic       right_shift,
  output logic [1:0] dir,
  output logic       running,
  output logic       game_over
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSE, DEAD} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       pend_q, pend_d;
  logic [3:0]       strobe_q, strobe_d;
  logic             set_q, set_d;
  logic             running_q, running_d;
  logic [5:0]       btn_q;
  logic [5:0]       btn_now;
  logic [5:0]       rise;
  logic             req_ok;
  logic [1:0]       req_dir;
  logic             tick_hit;

  // Bit order: {pause, start, right, left, down, up}
  assign btn_now = {btn_pause, start, btn_right, btn_left, btn_down, btn_up};
  assign rise    = btn_now & ~btn_q;

  // A request is legal only on the other axis from the committed heading,
  // which rules out both "same direction" and "reversal" in one compare.
  always_comb begin
    req_ok  = 1'b0;
    req_dir = 2'b00;
    for (int i = 3; i >= 0; i--) begin
      if (rise[i] && (i[1] != dir_q[1])) begin
        req_ok  = 1'b1;
        req_dir = 2'(i);
      end
    end
  end

`ifdef SNAKE_HIT_STOP_EN
  logic [3:0] edges;
  logic       game_over_q, game_over_d;
  assign edges = {edge_right, edge_left, edge_down, edge_up};
`else
  logic unused_edges;
  assign unused_edges = ^{edge_up, edge_down, edge_left, edge_right};
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    pend_d    = pend_q;
    strobe_d  = 4'b0000;
    tick_hit  = 1'b0;
    case (state_q)
      IDLE: if (rise[4]) state_d = LOAD;
      LOAD: begin
        cnt_d   = '0;
        dir_d   = 2'b00;
        pend_d  = 2'b00;
        state_d = RUN;
      end
      RUN: begin
        if (req_ok) pend_d = req_dir;
        if (rise[5]) begin
          state_d = PAUSE;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          dir_d = pend_d;
`ifdef SNAKE_HIT_STOP_EN
          tick_hit = edges[pend_d];
`endif
          if (tick_hit) state_d = DEAD;
          else          strobe_d = 4'b0001 << pend_d;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PAUSE: begin
        if (req_ok)  pend_d  = req_dir;
        if (rise[5]) state_d = RUN;
      end
      DEAD:    if (rise[4]) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  assign set_d     = (state_d == LOAD);
  assign running_d = (state_d == RUN);

  always_ff @(posedge clk) begin
    btn_q <= btn_now;
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dir_q     <= 2'b00;
      pend_q    <= 2'b00;
      strobe_q  <= 4'b0000;
      set_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      pend_q    <= pend_d;
      strobe_q  <= strobe_d;
      set_q     <= set_d;
      running_q <= running_d;
    end
  end

`ifdef SNAKE_HIT_STOP_EN
  assign game_over_d = (state_d == DEAD);
  always_ff @(posedge clk) begin
    if (reset) game_over_q <= 1'b0;
    else       game_over_q <= game_over_d;
  end
  assign game_over = game_over_q;
`else
  assign game_over = 1'b0;
`endif

  assign set         = set_q;
  assign user_input  = START_POS;
  assign up_shift    = strobe_q[0];
  assign down_shift  = strobe_q[1];
  assign left_shift  = strobe_q[2];
  assign right_shift = strobe_q[3];
  assign dir         = dir_q;
  assign running     = running_q;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed self-checking bench for snake_move_ctrl with TICK_DIV=4.
// Expectations follow SNAKE_HIT_STOP_EN when that macro is defined.
module tb_snake_move_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       btn_pause = 1'b0;
  logic       edge_up = 1'b0, edge_down = 1'b0, edge_left = 1'b0, edge_right = 1'b0;
  logic       set;
  logic [2:0] user_input;
  logic       up_shift, down_shift, left_shift, right_shift;
  logic [1:0] dir;
  logic       running;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  snake_move_ctrl #(.TICK_DIV(4), .START_POS(3'b111)) dut (
    .clk(clk), .reset(reset), .start(start),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_pause(btn_pause),
    .edge_up(edge_up), .edge_down(edge_down), .edge_left(edge_left), .edge_right(edge_right),
    .set(set), .user_input(user_input),
    .up_shift(up_shift), .down_shift(down_shift), .left_shift(left_shift), .right_shift(right_shift),
    .dir(dir), .running(running), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({set, up_shift, down_shift, left_shift, right_shift, running, game_over} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %b want 0000000",
               {set, up_shift, down_shift, left_shift, right_shift, running, game_over});
    end
    checks++;
    if (dir !== 2'b00) begin errors++; $display("[TB] FAIL reset_dir got %b want 00", dir); end
    checks++;
    if (user_input !== 3'b111) begin errors++; $display("[TB] FAIL reset_user_input got %b want 111", user_input); end
  endtask

  task automatic test_start();
    logic [3:0] want;
    start = 1'b1;
    tick();
    checks++;
    if (set !== 1'b1 || running !== 1'b0) begin
      errors++; $display("[TB] FAIL load_cycle set=%b running=%b want set=1 running=0", set, running);
    end
    start = 1'b0;
    tick();
    checks++;
    if (set !== 1'b0 || running !== 1'b1) begin
      errors++; $display("[TB] FAIL run_entry set=%b running=%b want set=0 running=1", set, running);
    end
    for (int c = 1; c <= 12; c++) begin
      tick();
      want = (c % 4 == 0) ? 4'b0001 : 4'b0000;
      checks++;
      if ({right_shift, left_shift, down_shift, up_shift} !== want || dir !== 2'b00) begin
        errors++;
        $display("[TB] FAIL up_cadence cycle %0d strobes(RLDU)=%b dir=%b want %b dir=00",
                 c, {right_shift, left_shift, down_shift, up_shift}, dir, want);
      end
    end
  endtask

  task automatic test_heading();
    btn_right = 1'b1;
    tick();
    btn_right = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({right_shift, left_shift, down_shift, up_shift} !== 4'b1000 || dir !== 2'b11) begin
      errors++;
      $display("[TB] FAIL turn_right strobes=%b dir=%b want 1000 dir=11",
               {right_shift, left_shift, down_shift, up_shift}, dir);
    end
    btn_left = 1'b1;
    tick();
    btn_left = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({right_shift, left_shift, down_shift, up_shift} !== 4'b1000 || dir !== 2'b11) begin
      errors++;
      $display("[TB] FAIL reject_reverse strobes=%b dir=%b want 1000 dir=11",
               {right_shift, left_shift, down_shift, up_shift}, dir);
    end
    btn_down = 1'b1;
    btn_left = 1'b1;
    tick();
    btn_down = 1'b0;
    btn_left = 1'b0;
    tick(); tick();
    checks++;
    if ({right_shift, left_shift, down_shift, up_shift} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL between_ticks strobes=%b want 0000", {right_shift, left_shift, down_shift, up_shift});
    end
    tick();
    checks++;
    if ({right_shift, left_shift, down_shift, up_shift} !== 4'b0010 || dir !== 2'b01) begin
      errors++;
      $display("[TB] FAIL priority_down strobes=%b dir=%b want 0010 dir=01",
               {right_shift, left_shift, down_shift, up_shift}, dir);
    end
  endtask

  task automatic test_pause();
    int bad;
    tick(); tick();
    btn_pause = 1'b1;
    tick();
    btn_pause = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) tick();
      if ({right_shift, left_shift, down_shift, up_shift, running} !== 5'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL pause_quiet got %0d bad cycles want 0", bad);
    end
    btn_pause = 1'b1;
    tick();
    btn_pause = 1'b0;
    checks++;
    if (running !== 1'b1 || down_shift !== 1'b0) begin
      errors++; $display("[TB] FAIL resume running=%b down=%b want running=1 down=0", running, down_shift);
    end
    tick();
    tick();
    checks++;
    if (down_shift !== 1'b1) begin errors++; $display("[TB] FAIL resume_strobe got %b want 1", down_shift); end
    tick(); tick(); tick();
    checks++;
    if (down_shift !== 1'b0) begin errors++; $display("[TB] FAIL resume_gap got %b want 0", down_shift); end
    tick();
    checks++;
    if (down_shift !== 1'b1) begin errors++; $display("[TB] FAIL resume_period got %b want 1", down_shift); end
  endtask

  task automatic test_pause_at_tick();
    tick(); tick(); tick();
    btn_pause = 1'b1;
    tick();
    btn_pause = 1'b0;
    checks++;
    if (down_shift !== 1'b0 || running !== 1'b0) begin
      errors++; $display("[TB] FAIL pause_wins down=%b running=%b want 0 0", down_shift, running);
    end
    tick(); tick();
    btn_pause = 1'b1;
    tick();
    btn_pause = 1'b0;
    checks++;
    if (down_shift !== 1'b0 || running !== 1'b1) begin
      errors++; $display("[TB] FAIL held_resume down=%b running=%b want 0 1", down_shift, running);
    end
    tick();
    checks++;
    if (down_shift !== 1'b1) begin errors++; $display("[TB] FAIL held_strobe got %b want 1", down_shift); end
  endtask

  task automatic test_reset_load();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b1;
    tick();
    checks++;
    if (set !== 1'b1) begin errors++; $display("[TB] FAIL reload_set got %b want 1", set); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (set !== 1'b0 || running !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_in_load set=%b running=%b want 0 0", set, running);
    end
    tick(); tick();
    checks++;
    if (set !== 1'b0 || running !== 1'b0) begin
      errors++; $display("[TB] FAIL held_start set=%b running=%b want 0 0", set, running);
    end
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (set !== 1'b1) begin errors++; $display("[TB] FAIL restart_set got %b want 1", set); end
    tick();
    checks++;
    if (running !== 1'b1 || dir !== 2'b00) begin
      errors++; $display("[TB] FAIL restart_run running=%b dir=%b want 1 00", running, dir);
    end
  endtask

  task automatic test_hit();
    edge_up = 1'b1;
    tick(); tick(); tick(); tick();
`ifdef SNAKE_HIT_STOP_EN
    checks++;
    if (up_shift !== 1'b0 || game_over !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hit_dead up=%b game_over=%b running=%b want 0 1 0", up_shift, game_over, running);
    end
    edge_up = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (set !== 1'b1 || game_over !== 1'b0) begin
      errors++; $display("[TB] FAIL dead_restart set=%b game_over=%b want 1 0", set, game_over);
    end
`else
    checks++;
    if (up_shift !== 1'b1 || game_over !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("[TB] FAIL edge_ignored up=%b game_over=%b running=%b want 1 0 1", up_shift, game_over, running);
    end
    edge_up = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (set !== 1'b0 || running !== 1'b1) begin
      errors++; $display("[TB] FAIL start_in_run set=%b running=%b want 0 1", set, running);
    end
`endif
  endtask

  initial begin
    tick();
    test_reset();
    test_start();
    test_heading();
    test_pause();
    test_pause_at_tick();
    test_reset_load();
    test_hit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
